// File: rtl/vram_text_writer.sv
// vram_text_writer: text-mode front end that fills character VRAM.
// Accepts one code per handshake, writes it at the cursor, handles CR/LF/BS/FF
// and scrolls the screen up one row when the cursor runs off the last row.
module vram_text_writer #(
  parameter int          COLS  = 40,
  parameter int          ROWS  = 30,
  parameter logic [9:0]  BLANK = 10'h020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_data,
  output logic [11:0] vram_addr,
  output logic        vram_we,
  output logic [31:0] vram_wdata,
  input  logic [31:0] vram_rdata,
  output logic [5:0]  cursor_row,
  output logic [5:0]  cursor_col,
  output logic        busy
);

  localparam logic [5:0] LAST_C = 6'(COLS - 1);
  localparam logic [5:0] LAST_R = 6'(ROWS - 1);
  localparam logic [9:0] C_BS = 10'h008, C_LF = 10'h00A, C_FF = 10'h00C, C_CR = 10'h00D;

  typedef enum logic [2:0] {IDLE, PUT, CLEAR, SC_RD, SC_WR, SC_FILL} state_t;

  state_t     state, state_nx;
  logic [5:0] row, col;     // cursor
  logic [5:0] sr, sc;       // clear / scroll scan position
  logic [9:0] code;         // word written by PUT
  logic       adv;          // PUT advances the cursor (printable) or not (BS)
  logic       acc_q;        // a code was accepted last cycle
  logic       accept;
  logic       scan_last;
  logic [5:0] sr_m1;
  logic       unused_rdata;

  assign unused_rdata = ^vram_rdata[31:10];
  assign cmd_ready    = (state == IDLE) && !acc_q;
  assign accept       = cmd_ready && cmd_valid;
  assign scan_last    = (sr == LAST_R) && (sc == LAST_C);
  assign sr_m1        = sr - 6'd1;
  assign cursor_row   = row;
  assign cursor_col   = col;
  assign busy         = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and VRAM port drive
  always_comb begin
    state_nx   = state;
    vram_we    = 1'b0;
    vram_addr  = 12'h000;
    vram_wdata = 32'h0;
    case (state)
      IDLE: if (accept) begin
        case (cmd_data)
          C_CR: state_nx = IDLE;
          C_LF: state_nx = (row == LAST_R) ? SC_RD : IDLE;
          C_BS: state_nx = (row != 6'd0 || col != 6'd0) ? PUT : IDLE;
          C_FF: state_nx = CLEAR;
          default: state_nx = PUT;
        endcase
      end
      PUT: begin
        vram_we    = 1'b1;
        vram_addr  = {row, col};
        vram_wdata = {22'd0, code};
        state_nx   = (adv && col == LAST_C && row == LAST_R) ? SC_RD : IDLE;
      end
      CLEAR: begin
        vram_we    = 1'b1;
        vram_addr  = {sr, sc};
        vram_wdata = {22'd0, BLANK};
        if (scan_last) state_nx = IDLE;
      end
      SC_RD: begin
        vram_addr = {sr, sc};
        state_nx  = SC_WR;
      end
      SC_WR: begin
        vram_we    = 1'b1;
        vram_addr  = {sr_m1, sc};
        vram_wdata = {22'd0, vram_rdata[9:0]};
        state_nx   = scan_last ? SC_FILL : SC_RD;
      end
      SC_FILL: begin
        vram_we    = 1'b1;
        vram_addr  = {LAST_R, sc};
        vram_wdata = {22'd0, BLANK};
        if (sc == LAST_C) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Cursor, scan counters and latched code
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row   <= 6'd0;
      col   <= 6'd0;
      sr    <= 6'd0;
      sc    <= 6'd0;
      code  <= 10'd0;
      adv   <= 1'b0;
      acc_q <= 1'b0;
    end else begin
      acc_q <= accept;
      case (state)
        IDLE: if (accept) begin
          case (cmd_data)
            C_CR: col <= 6'd0;
            C_LF: begin
              col <= 6'd0;
              if (row != LAST_R) row <= row + 6'd1;
              else begin sr <= 6'd1; sc <= 6'd0; end
            end
            C_BS: begin
              // cursor moves back first; PUT then blanks the new position
              code <= BLANK;
              adv  <= 1'b0;
              if (col != 6'd0) col <= col - 6'd1;
              else if (row != 6'd0) begin
                row <= row - 6'd1;
                col <= LAST_C;
              end
            end
            C_FF: begin sr <= 6'd0; sc <= 6'd0; end
            default: begin code <= cmd_data; adv <= 1'b1; end
          endcase
        end
        PUT: if (adv) begin
          if (col == LAST_C) begin
            col <= 6'd0;
            if (row != LAST_R) row <= row + 6'd1;
            else begin sr <= 6'd1; sc <= 6'd0; end
          end else col <= col + 6'd1;
        end
        CLEAR, SC_WR: begin
          if (sc == LAST_C) begin sc <= 6'd0; sr <= sr + 6'd1; end
          else sc <= sc + 6'd1;
          if (state == CLEAR && scan_last) begin row <= 6'd0; col <= 6'd0; end
        end
        SC_FILL: begin
          sc <= sc + 6'd1;
          if (sc == LAST_C) begin row <= LAST_R; col <= 6'd0; end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_text_writer.sv
// Bench for vram_text_writer: VRAM memory model plus a character-screen
// reference model (2-D array + cursor) driven by directed and random codes.
module tb_vram_text_writer;
  localparam int COLS = 40, ROWS = 30;
  localparam logic [9:0] BLANK = 10'h020;

  logic        clk = 1'b0, reset = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [9:0]  cmd_data = 10'd0;
  logic [11:0] vram_addr;
  logic        vram_we;
  logic [31:0] vram_wdata, vram_rdata;
  logic [5:0]  cursor_row, cursor_col;
  logic        busy;

  int n_tests = 0, n_fail = 0;

  vram_text_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .vram_addr(vram_addr), .vram_we(vram_we),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy));

  always #5 clk = ~clk;

  // VRAM model and write monitor
  logic [9:0]  mem [0:4095];
  int          wr_cnt = 0, busy_cnt = 0, bad_wr = 0, non_blank = 0;
  logic [11:0] last_addr;
  logic [31:0] last_data;

  always @(posedge clk) begin
    vram_rdata <= {22'd0, mem[vram_addr]};
    if (busy) busy_cnt <= busy_cnt + 1;
    if (vram_we) begin
      mem[vram_addr] <= vram_wdata[9:0];
      wr_cnt    <= wr_cnt + 1;
      last_addr <= vram_addr;
      last_data <= vram_wdata;
      if (vram_wdata[9:0] != BLANK) non_blank <= non_blank + 1;
      if (vram_addr[11:6] >= 6'(ROWS) || vram_addr[5:0] >= 6'(COLS) || vram_wdata[31:10] != 22'd0)
        bad_wr <= bad_wr + 1;
    end
  end

  // Reference screen model
  int exp_scr [0:ROWS-1][0:COLS-1];
  int mrow = 0, mcol = 0;

  function automatic void model_scroll();
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++) exp_scr[r][c] = exp_scr[r+1][c];
    for (int c = 0; c < COLS; c++) exp_scr[ROWS-1][c] = BLANK;
  endfunction

  function automatic void model_apply(input int code);
    case (code)
      13: mcol = 0;
      10: begin
        mcol = 0;
        if (mrow < ROWS - 1) mrow++; else model_scroll();
      end
      8: begin
        if (mcol > 0) begin mcol--; exp_scr[mrow][mcol] = BLANK; end
        else if (mrow > 0) begin mrow--; mcol = COLS - 1; exp_scr[mrow][mcol] = BLANK; end
      end
      12: begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) exp_scr[r][c] = BLANK;
        mrow = 0; mcol = 0;
      end
      default: begin
        exp_scr[mrow][mcol] = code;
        mcol++;
        if (mcol == COLS) begin
          mcol = 0;
          if (mrow == ROWS - 1) model_scroll(); else mrow++;
        end
      end
    endcase
  endfunction

  function automatic int screen_diffs();
    int d = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (int'(mem[{6'(r), 6'(c)}]) != exp_scr[r][c]) d++;
    return d;
  endfunction

  // Drive one code (called at a negedge), then wait for the block to go idle
  task automatic send(input logic [9:0] code);
    int n = 0;
    cmd_data = code; cmd_valid = 1'b1;
    while (!cmd_ready && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    model_apply(int'(code));
    n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    n_tests++;
    if (busy) begin n_fail++; $display("FAIL idle_timeout code=%h still busy", code); end
    @(negedge clk);
  endtask

  task automatic clr_cnt();
    wr_cnt = 0; busy_cnt = 0; non_blank = 0;
  endtask

  task automatic check_cursor(input string tag);
    n_tests++;
    if (cursor_row !== 6'(mrow) || cursor_col !== 6'(mcol)) begin
      n_fail++;
      $display("FAIL cursor_%s got (%0d,%0d) want (%0d,%0d)", tag, cursor_row, cursor_col, mrow, mcol);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    mrow = 0; mcol = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    n_tests++;
    if ({vram_we, vram_addr, vram_wdata, cmd_ready, busy, cursor_row, cursor_col} !==
        {1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 6'd0, 6'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs we=%b addr=%h wd=%h rdy=%b busy=%b cur=(%0d,%0d)",
               vram_we, vram_addr, vram_wdata, cmd_ready, busy, cursor_row, cursor_col);
    end
    @(negedge clk); reset = 1'b1; @(negedge clk);
  endtask

  task automatic test_put_a();
    clr_cnt(); send(10'h041);
    n_tests++;
    if (wr_cnt != 1 || last_addr !== 12'h000 || last_data !== 32'h41) begin
      n_fail++; $display("FAIL put_a cnt=%0d addr=%h data=%h want 1/000/41", wr_cnt, last_addr, last_data);
    end
    check_cursor("put_a");
  endtask

  task automatic test_row_wrap();
    do_reset(); clr_cnt();
    for (int i = 0; i < COLS; i++) send(10'($urandom_range(32, 1023)));
    n_tests++;
    if (wr_cnt != COLS || last_addr !== 12'h027) begin
      n_fail++; $display("FAIL row_wrap cnt=%0d last_addr=%h want %0d/027", wr_cnt, last_addr, COLS);
    end
    check_cursor("row_wrap");
  endtask

  task automatic test_backspace();
    do_reset();
    for (int i = 0; i < 5; i++) send(10'h00A);
    clr_cnt(); send(10'h008);
    n_tests++;
    if (wr_cnt != 1 || last_addr !== 12'h127 || last_data !== 32'h20) begin
      n_fail++; $display("FAIL bs_wrap cnt=%0d addr=%h data=%h want 1/127/20", wr_cnt, last_addr, last_data);
    end
    check_cursor("bs_wrap");
    do_reset(); clr_cnt(); send(10'h008);
    n_tests++;
    if (wr_cnt != 0) begin n_fail++; $display("FAIL bs_origin writes=%0d want 0", wr_cnt); end
    check_cursor("bs_origin");
  endtask

  task automatic test_clear();
    clr_cnt(); send(10'h00C);
    n_tests++;
    if (wr_cnt != ROWS*COLS || non_blank != 0 || busy_cnt != ROWS*COLS) begin
      n_fail++; $display("FAIL clear writes=%0d nonblank=%0d busy=%0d want %0d/0/%0d",
                         wr_cnt, non_blank, busy_cnt, ROWS*COLS, ROWS*COLS);
    end
    check_cursor("clear");
    n_tests++;
    if (screen_diffs() != 0) begin n_fail++; $display("FAIL clear_screen diffs=%0d want 0", screen_diffs()); end
  endtask

  task automatic test_scroll();
    do_reset();
    mem[{6'd1, 6'd0}] = 10'h055; exp_scr[1][0] = 10'h055;
    for (int i = 0; i < ROWS - 1; i++) send(10'h00A);
    for (int i = 0; i < 3; i++) send(10'($urandom_range(32, 1023)));
    check_cursor("pre_scroll");
    clr_cnt(); send(10'h00A);
    n_tests++;
    if (busy_cnt != 2*COLS*(ROWS-1) + COLS) begin
      n_fail++; $display("FAIL scroll_busy got %0d want %0d", busy_cnt, 2*COLS*(ROWS-1) + COLS);
    end
    n_tests++;
    if (mem[0] !== 10'h055) begin n_fail++; $display("FAIL scroll_moved got %h want 055", mem[0]); end
    n_tests++;
    if (screen_diffs() != 0) begin n_fail++; $display("FAIL scroll_screen diffs=%0d want 0", screen_diffs()); end
    check_cursor("scroll");
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    cmd_data = 10'h00D; cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (cmd_ready) begin acc++; model_apply(13); end
      @(negedge clk);
    end
    cmd_valid = 1'b0; @(negedge clk);
    n_tests++;
    if (acc != 5) begin n_fail++; $display("FAIL back_to_back accepts=%0d want 5", acc); end
    check_cursor("b2b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 160; i++) begin
      int p = $urandom_range(0, 99);
      logic [9:0] code;
      if (p < 4) code = 10'h00A;
      else if (p < 8) code = 10'h00D;
      else if (p < 16) code = 10'h008;
      else code = 10'($urandom_range(32, 1023));
      send(code);
      check_cursor("random");
    end
    n_tests++;
    if (screen_diffs() != 0) begin n_fail++; $display("FAIL random_screen diffs=%0d want 0", screen_diffs()); end
  endtask

  task automatic test_reset_mid_clear();
    cmd_data = 10'h00C; cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    repeat (100) @(negedge clk);
    @(posedge clk); #2 reset = 1'b0; #1;
    n_tests++;
    if ({vram_we, vram_addr, vram_wdata, cmd_ready, busy, cursor_row, cursor_col} !==
        {1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 6'd0, 6'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_clear we=%b addr=%h wd=%h rdy=%b busy=%b", vram_we, vram_addr, vram_wdata, cmd_ready, busy);
    end
    @(negedge clk); reset = 1'b1; @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ready_after_release rdy=%b busy=%b want 1/0", cmd_ready, busy);
    end
    mrow = 0; mcol = 0;
    send(10'h00C);   // resync screen with the model
    n_tests++;
    if (screen_diffs() != 0) begin n_fail++; $display("FAIL post_abort_clear diffs=%0d want 0", screen_diffs()); end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 10'($urandom);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) exp_scr[r][c] = int'(mem[{6'(r), 6'(c)}]);
    @(negedge clk);
    test_reset();
    test_put_a();
    test_row_wrap();
    test_backspace();
    test_clear();
    test_scroll();
    test_back_to_back();
    test_random();
    test_reset_mid_clear();
    n_tests++;
    if (bad_wr != 0) begin n_fail++; $display("FAIL illegal_writes got %0d want 0", bad_wr); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
